// File: rtl/fifo_wr_arbiter_if.sv
// Channel-side handshake and FIFO write-port bundle for fifo_wr_arbiter.
// master = the arbiter, slave = producers plus the FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int STALL_W = 16
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int FIFO_W = CH_W + DATA_W;

  logic [NUM_CH-1:0]        i_ch_valid;
  logic [NUM_CH-1:0]        o_ch_ready;
  logic [NUM_CH*DATA_W-1:0] i_ch_data;
  logic                     i_wr_full;
  logic                     o_wr_inc;
  logic [FIFO_W-1:0]        o_wr_data;
  logic [NUM_CH-1:0]        o_grant;
  logic [STALL_W-1:0]       o_stall_cnt;

  modport master (
    input  i_ch_valid, i_ch_data, i_wr_full,
    output o_ch_ready, o_wr_inc, o_wr_data, o_grant, o_stall_cnt
  );

  modport slave (
    output i_ch_valid, i_ch_data, i_wr_full,
    input  o_ch_ready, o_wr_inc, o_wr_data, o_grant, o_stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_CH one-entry holding registers.
// Sample accepted at edge t is written at t+1 earliest; i_wr_full stalls writes and channel ready combinationally.
module fifo_wr_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fifo_wr_arbiter_if.master     bus
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int FIFO_W = CH_W + DATA_W;

  logic [NUM_CH-1:0]  hold_vld;
  logic [DATA_W-1:0]  hold_data [NUM_CH];
  logic [CH_W-1:0]    rr_ptr;
  logic [STALL_W-1:0] stall_cnt;

  logic               cand_vld;
  logic [CH_W-1:0]    cand;
  logic [CH_W-1:0]    idx;
  int                 s;
  logic               wr_inc;
  logic [NUM_CH-1:0]  grant;
  logic [NUM_CH-1:0]  ready;
  logic [FIFO_W-1:0]  wr_data;

  // Walk channels starting at rr_ptr; the wrap is explicit so non-power-of-2 counts work.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    s        = 0;
    idx      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      idx = CH_W'(s);
      if (!cand_vld && hold_vld[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end

  always_comb begin
    wr_inc  = cand_vld && !bus.i_wr_full && !i_rst;
    grant   = wr_inc ? (NUM_CH'(1) << cand) : '0;
    wr_data = wr_inc ? {cand, hold_data[cand]} : '0;
    // A draining slot may refill in the same cycle.
    ready   = {NUM_CH{!i_rst}} & (~hold_vld | grant);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_vld  <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.i_ch_valid[c] && ready[c]) begin
          hold_vld[c]  <= 1'b1;
          hold_data[c] <= bus.i_ch_data[c*DATA_W +: DATA_W];
        end else if (grant[c]) begin
          hold_vld[c] <= 1'b0;
        end
      end
      if (wr_inc) begin
        if (cand == CH_W'(NUM_CH-1)) rr_ptr <= '0;
        else                         rr_ptr <= cand + 1'b1;
      end
      if (bus.i_wr_full && (|hold_vld) && (stall_cnt != {STALL_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.o_ch_ready  = ready;
  assign bus.o_wr_inc    = wr_inc;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_grant     = grant;
  assign bus.o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random stimulus against per-channel scoreboard queues and a round-robin reference.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_CH(N), .DATA_W(DW), .STALL_W(SW)) bus ();
  fifo_wr_arbiter #(.NUM_CH(N), .DATA_W(DW), .STALL_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  int checks = 0;
  int fails  = 0;
  int total_acc = 0, total_wr = 0, discarded = 0;

  // Expected contents of each channel's holding slot, oldest first.
  logic [DW-1:0] sb [N][$];
  int rr = 0;
  int stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: inputs are stable between posedge+1 and the next posedge.
  always @(negedge clk) begin
    bit found;
    int g;
    int c;
    logic [N-1:0] exp_grant, exp_ready;
    bit exp_inc;
    logic [9:0] exp_data;
    logic [1:0] gl;
    found = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      c = (rr + k) % N;
      if (!found && sb[c].size() != 0) begin found = 1; g = c; end
    end
    exp_inc   = found && !bus.i_wr_full && !rst;
    exp_grant = exp_inc ? (N'(1) << g) : '0;
    for (int k = 0; k < N; k++)
      exp_ready[k] = !rst && (sb[k].size() == 0 || (exp_inc && g == k));
    chk("wr_inc", 32'(bus.o_wr_inc), 32'(exp_inc));
    chk("grant", 32'(bus.o_grant), 32'(exp_grant));
    chk("ch_ready", 32'(bus.o_ch_ready), 32'(exp_ready));
    chk("stall_cnt", 32'(bus.o_stall_cnt), stall);
    if (exp_inc) begin
      gl = 2'(g);
      exp_data = {gl, sb[g][0]};
      chk("wr_data", 32'(bus.o_wr_data), 32'(exp_data));
    end else if (rst) begin
      chk("wr_data_rst", 32'(bus.o_wr_data), 32'd0);
    end
    // Advance the reference to the state after the coming edge.
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        discarded += sb[k].size();
        sb[k].delete();
      end
      rr = 0;
      stall = 0;
    end else begin
      if (exp_inc) begin
        void'(sb[g].pop_front());
        total_wr++;
        rr = (g + 1) % N;
      end
      if (found && bus.i_wr_full && stall < SMAX) stall++;
      for (int k = 0; k < N; k++)
        if (bus.i_ch_valid[k] && exp_ready[k]) begin
          sb[k].push_back(bus.i_ch_data[k*DW +: DW]);
          total_acc++;
        end
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] v, input logic f, input logic [31:0] d);
    rst = r;
    bus.i_ch_valid = v;
    bus.i_wr_full  = f;
    bus.i_ch_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all channels requesting.
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 1'b0, 32'h13121110);
    // Full load round robin.
    for (int i = 0; i < 12; i++) drive(1'b0, 4'b1111, 1'b0, 32'h13121110);
    // Sparse requesters, then ch1 alone.
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b1010, 1'b0, $urandom);
    for (int i = 0; i < 6; i++)  drive(1'b0, 4'b0010, 1'b0, $urandom);
    for (int i = 0; i < 3; i++)  drive(1'b0, 4'b0000, 1'b0, 32'h0);
    // Full stall with ch2 holding A5, then release.
    drive(1'b0, 4'b0100, 1'b0, 32'h00A50000);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b0100, 1'b1, 32'h00110000);
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    // Stall counter saturation.
    drive(1'b0, 4'b0001, 1'b0, 32'h0000005A);
    for (int i = 0; i < 20; i++) drive(1'b0, 4'b0000, 1'b1, 32'h0);
    // Reset while words are pending discards them.
    drive(1'b0, 4'b1111, 1'b1, $urandom);
    drive(1'b1, 4'b1111, 1'b1, $urandom);
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    // Random traffic with random full and occasional reset.
    for (int i = 0; i < 2000; i++)
      drive(($urandom_range(0, 299) == 0), 4'($urandom), ($urandom_range(0, 3) == 0), $urandom);
    // Drain and confirm every accepted sample was written or explicitly discarded.
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) chk("drained", 32'(sb[k].size()), 32'd0);
    chk("conservation", total_wr + discarded, total_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
